data_mem_responder: RTL and testbench

- Responder end of the processor's data-memory interface.
- Services the load/store requests that the pipeline's MEM stage issues via mem_read/mem_write.
- Models a multi-cycle memory: holds mem_stall high so the hazard logic freezes the pipeline until the access completes.
- Replaces the single-cycle data memory for latency-sensitive testbenches.

---
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store at a time, stalls the pipeline for LATENCY cycles,
// then completes the access with a one-cycle mem_ready (and addr_error) pulse.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        mem_ready,
    output logic        addr_error
);
    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_BUSY     = 2'd1;
    localparam logic [1:0]  S_DONE     = 2'd2;
    // BUSY lasts LATENCY-1 cycles; counter runs LATENCY-2 .. 0
    localparam logic [3:0]  CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] read_data_q, read_data_d;
    logic        mem_ready_q, mem_ready_d;
    logic        addr_error_q, addr_error_d;

    logic [31:0] mem_q [DEPTH];

    logic             req;
    logic             finish;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_wr;
    logic             acc_legal;
    logic [IDX_W-1:0] acc_idx;
    logic             mem_we;

    assign req = mem_read | mem_write;

    // Next-state, request latching and completion of the access
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        read_data_d  = read_data_q;
        mem_ready_d  = 1'b0;
        addr_error_d = 1'b0;
        finish       = 1'b0;
        // the latched request is used except when a single-cycle access
        // completes straight out of IDLE
        acc_addr     = addr_q;
        acc_wdata    = wdata_q;
        acc_wr       = wr_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    wr_d    = mem_write;   // write wins when both are high
                    if (LATENCY == 1) begin
                        state_d   = S_DONE;
                        finish    = 1'b1;
                        acc_addr  = address;
                        acc_wdata = write_data;
                        acc_wr    = mem_write;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;   // a request here waits for IDLE
            default: state_d = S_IDLE;
        endcase

        acc_legal = (acc_addr[1:0] == 2'b00) && (acc_addr < ADDR_LIMIT);
        acc_idx   = acc_addr[IDX_W+1:2];
        mem_we    = finish & acc_wr & acc_legal;

        if (finish) begin
            mem_ready_d  = 1'b1;
            addr_error_d = ~acc_legal;
            if (!acc_wr) begin
                read_data_d = acc_legal ? mem_q[acc_idx] : 32'd0;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wr_q         <= 1'b0;
            read_data_q  <= 32'd0;
            mem_ready_q  <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            read_data_q  <= read_data_d;
            mem_ready_q  <= mem_ready_d;
            addr_error_q <= addr_error_d;
        end
    end

    // Storage array; reset clears every word and drops any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign mem_stall  = ((state_q == S_IDLE) & req) | (state_q == S_BUSY);
    assign read_data  = read_data_q;
    assign mem_ready  = mem_ready_q;
    assign addr_error = addr_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 3 and 1) share one
// stimulus stream and are compared every cycle against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_data_mem_responder;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;

    logic [31:0] rd3, rd1;
    logic        st3, st1, rdy3, rdy1, er3, er1;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(rd3),
        .mem_stall(st3), .mem_ready(rdy3), .addr_error(er3)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(rd1),
        .mem_stall(st1), .mem_ready(rdy1), .addr_error(er1)
    );

    // ---------------- behavioural model (index 0: LATENCY 3, 1: LATENCY 1)
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_w    [2];
    bit          m_rdy  [2];
    bit          m_err  [2];
    int          m_k    [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rd   [2];
    logic [31:0] m_mem  [2][DEPTH];

    function automatic int lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    // m_k counts edges since acceptance; the access lands when it reaches LATENCY
    task automatic model_step(input int d);
        bit fin;
        bit legal;
        fin = 1'b0;
        if (rst) begin
            m_busy[d] = 0; m_done[d] = 0; m_rdy[d] = 0; m_err[d] = 0;
            m_rd[d] = 32'd0;
            for (int i = 0; i < DEPTH; i++) m_mem[d][i] = 32'd0;
            return;
        end
        if (m_done[d]) begin
            m_done[d] = 0;
        end else if (m_busy[d]) begin
            m_k[d]++;
            if (m_k[d] == lat(d)) begin
                m_busy[d] = 0;
                fin = 1'b1;
            end
        end else if (mem_read || mem_write) begin
            m_w[d]  = mem_write;
            m_a[d]  = address;
            m_wd[d] = write_data;
            if (lat(d) == 1) fin = 1'b1;
            else begin
                m_busy[d] = 1;
                m_k[d] = 1;
            end
        end
        m_rdy[d] = fin;
        m_err[d] = 0;
        if (fin) begin
            legal = (m_a[d][1:0] == 2'b00) && (m_a[d] < 4 * DEPTH);
            m_err[d] = !legal;
            if (m_w[d]) begin
                if (legal) m_mem[d][m_a[d][9:2]] = m_wd[d];
            end else begin
                m_rd[d] = legal ? m_mem[d][m_a[d][9:2]] : 32'd0;
            end
        end
        m_done[d] = fin;
    endtask

    function automatic logic exp_stall(input int d);
        return m_busy[d] || (!m_done[d] && (mem_read || mem_write));
    endfunction

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison of both instances against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("l3_read_data", rd3, m_rd[0]);
            chk("l3_mem_stall", 32'(st3), 32'(exp_stall(0)));
            chk("l3_mem_ready", 32'(rdy3), 32'(m_rdy[0]));
            chk("l3_addr_error", 32'(er3), 32'(m_err[0]));
            chk("l1_read_data", rd1, m_rd[1]);
            chk("l1_mem_stall", 32'(st1), 32'(exp_stall(1)));
            chk("l1_mem_ready", 32'(rdy1), 32'(m_rdy[1]));
            chk("l1_addr_error", 32'(er1), 32'(m_err[1]));
        end
    end

    // one access on the LATENCY-3 instance; inputs dropped after drop_at cycles
    task automatic access3(input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] d, input int drop_at,
                           output int stalls, output logic [31:0] rdv, output logic erv);
        int cyc;
        bit got;
        stalls = 0; got = 0; rdv = 32'd0; erv = 1'b0; cyc = 0;
        @(posedge clk); #1;
        mem_write = w; mem_read = r; address = a; write_data = d;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rdy3) begin
                got = 1; rdv = rd3; erv = er3;
            end else begin
                if (st3) stalls++;
                @(posedge clk); #1;
                if (cyc == drop_at) begin
                    mem_write = 0; mem_read = 0;
                    address = $urandom; write_data = $urandom;
                end
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL access_timeout addr=%h: no mem_ready within 20 cycles", a);
        end
        @(posedge clk); #1;
        mem_write = 0; mem_read = 0;
    endtask

    initial begin
        int          stl;
        logic [31:0] rdv;
        logic        erv;
        int          nrdy, nstl;
        logic [1:0]  rw;

        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("reset_read_data", rd3, 32'd0);
        chk("reset_stall", 32'(st3), 32'd0);
        chk("reset_ready", 32'(rdy3), 32'd0);

        // store then load, 3-cycle stall each
        access3(1, 0, 32'h10, 32'hDEADBEEF, 0, stl, rdv, erv);
        chk("p1_store_stalls", 32'(stl), 32'd3);
        chk("p1_store_err", 32'(erv), 32'd0);
        access3(0, 1, 32'h10, 32'h0, 0, stl, rdv, erv);
        chk("p1_load_stalls", 32'(stl), 32'd3);
        chk("p1_load_data", rdv, 32'hDEADBEEF);

        // illegal stores are suppressed, illegal load returns 0
        access3(1, 0, 32'h13, 32'h11111111, 0, stl, rdv, erv);
        chk("p3_misaligned_err", 32'(erv), 32'd1);
        access3(1, 0, 32'h400, 32'h22222222, 0, stl, rdv, erv);
        chk("p3_range_err", 32'(erv), 32'd1);
        access3(0, 1, 32'h10, 32'h0, 0, stl, rdv, erv);
        chk("p3_word4_kept", rdv, 32'hDEADBEEF);
        access3(0, 1, 32'h13, 32'h0, 0, stl, rdv, erv);
        chk("p3_bad_load_data", rdv, 32'd0);
        chk("p3_bad_load_err", 32'(erv), 32'd1);

        // read+write together acts as a write
        access3(0, 1, 32'h10, 32'h0, 0, stl, rdv, erv);
        access3(1, 1, 32'h20, 32'h5, 0, stl, rdv, erv);
        chk("p4_rd_held", rdv, 32'hDEADBEEF);
        access3(0, 1, 32'h20, 32'h0, 0, stl, rdv, erv);
        chk("p4_load", rdv, 32'h5);

        // inputs drop during the second BUSY cycle
        access3(1, 0, 32'h30, 32'hCAFEF00D, 2, stl, rdv, erv);
        chk("p5_stalls", 32'(stl), 32'd3);
        access3(0, 1, 32'h30, 32'h0, 0, stl, rdv, erv);
        chk("p5_load", rdv, 32'hCAFEF00D);

        // back-to-back loads on the single-cycle instance
        access3(1, 0, 32'h8, 32'h0000A5A5, 0, stl, rdv, erv);
        repeat (3) @(posedge clk);
        #1 mem_read = 1; address = 32'h8;
        nrdy = 0; nstl = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy1) nrdy++;
            if (st1) nstl++;
        end
        chk("p2_ready_pulses", 32'(nrdy), 32'd4);
        chk("p2_stall_cycles", 32'(nstl), 32'd4);
        chk("p2_data", rd1, 32'h0000A5A5);
        @(posedge clk); #1 mem_read = 0;
        repeat (6) @(posedge clk);

        // reset during BUSY abandons the store
        #1 mem_write = 1; address = 32'h40; write_data = 32'h1234;
        @(posedge clk); #1;
        mem_write = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("p6_stall", 32'(st3), 32'd0);
        chk("p6_read_data", rd3, 32'd0);
        access3(0, 1, 32'h40, 32'h0, 0, stl, rdv, erv);
        chk("p6_load", rdv, 32'd0);

        // randomized traffic
        repeat (600) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 99) == 0);
            rw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) rw = 2'b00;
            mem_read = rw[0];
            mem_write = rw[1];
            case ($urandom_range(0, 7))
                0: address = $urandom;
                1: address = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                2: address = 32'h400 + (32'($urandom_range(0, 15)) << 2);
                default: address = 32'($urandom_range(0, 15)) << 2;
            endcase
            write_data = $urandom;
        end
        @(posedge clk); #1;
        rst = 0; mem_read = 0; mem_write = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
